w5300_bus_ctrl: RTL and testbench
=================================

W5300_BUS_CTRL -- requirements
Module: w5300_bus_ctrl

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1: cycles with cs_n low and address valid before the strobe falls (legal range 1..15).
REQ-002 SHALL have parameter PULSE_CYC, default 2: cycles the rd_n/wr_n strobe is held low (legal range 1..15).
REQ-003 SHALL have parameter HOLD_CYC, default 1: cycles with cs_n low, strobe high and address/data held after the strobe rises (legal range 1..15).
REQ-004 SHALL have ports: clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: cpu_req, cpu_rnw, cpu_addr, cpu_wdata  in  1, 1, 10, 8  requester 0 (CPU side) request, read-not-write, address, write data.
REQ-007 SHALL have ports: dma_req, dma_rnw, dma_addr, dma_wdata  in  1, 1, 10, 8  requester 1 (DMA side), same meaning.
REQ-008 SHALL have ports: cpu_ack, dma_ack  out  1 each  one-cycle completion pulse per requester.
REQ-009 SHALL have ports: rdata  out  8  read data, shared, valid while either ack is high.
REQ-010 SHALL have ports: w_addr  out  10; w_cs_n, w_rd_n, w_wr_n  out  1 each  chip bus toward the W5300.
REQ-011 SHALL have ports: w_dout  out  8; w_doe  out  1; w_din  in  8  split data bus; the top level builds the tristate.
REQ-012 SHALL have ports: w_int_n  in  1  asynchronous chip interrupt; irq  out  1  synchronized, active-high interrupt.

Function
REQ-013 SHALL implement the FSM IDLE -> SETUP -> PULSE -> HOLD -> IDLE, with a 4-bit down-counter loaded on each state entry.
REQ-014 SHALL, in IDLE, sample the requests; if any request is high, latch the winner's rnw/addr/wdata and enter SETUP on the next edge.
REQ-015 SHALL arbitrate round-robin: with a single request, that requester wins; with both requests high, the requester not granted last wins.
REQ-016 SHALL drive, in SETUP for SETUP_CYC cycles: w_cs_n=0, w_addr=latched addr, w_rd_n=w_wr_n=1, and w_doe=1 with w_dout=wdata for writes.
REQ-017 SHALL drive, in PULSE for PULSE_CYC cycles: w_rd_n=0 (read) or w_wr_n=0 (write), with cs_n, addr and data unchanged.
REQ-018 SHALL capture w_din into rdata on the clock edge that ends PULSE for reads, and SHALL leave rdata unchanged on writes.
REQ-019 SHALL hold, in HOLD for HOLD_CYC cycles: strobes high, cs_n low, addr and w_doe/w_dout unchanged.
REQ-020 SHALL assert the granted requester's ack during the final HOLD cycle only.
REQ-021 SHALL give a latency from the accepting IDLE edge to ack of SETUP_CYC+PULSE_CYC+HOLD_CYC cycles; with defaults, ack is in the 4th cycle after acceptance.
REQ-022 SHALL require each requester to hold req/rnw/addr/wdata stable until its ack; the latched copy, not the live inputs, drives the bus.
REQ-023 SHALL spend at least one IDLE cycle between transactions, with w_cs_n=1, w_doe=0 and both strobes high.
REQ-024 SHALL never have rd_n and wr_n low together, and SHALL have w_doe=1 only while w_cs_n=0 on a write.
REQ-025 SHALL ignore a request deasserted before ack (protocol violation); the transaction still completes and ack still pulses.
REQ-026 SHALL produce irq through a two-flop synchronizer on w_int_n followed by inversion, giving a 2-cycle latency.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, set: state=IDLE; w_cs_n=w_rd_n=w_wr_n=1; w_doe=0; w_dout=0; w_addr=0; rdata=0; acks=0; synchronizer flops=1 (irq=0); last-grant=DMA, so the CPU wins the first tie.
REQ-028 SHALL, on reset mid-transaction, release all strobes on that edge and issue no ack for the aborted access.

Structure
REQ-029 SHALL place the state encoding and the W5300 address width (10) and data width (8) in shared package w5300_pkg.
REQ-030 SHALL place the interrupt synchronizer in one sub-module, sync2, reusable elsewhere.

Verification
REQ-031 SHALL cover: defaults, CPU write 0x3A5 <- 0x5C -> cs_n low 4 cycles, wr_n low 2 cycles, w_dout=0x5C with w_doe=1 throughout, cpu_ack 4 cycles after acceptance.
REQ-032 SHALL cover: DMA read 0x012 with the bench model returning 0xC3 -> rd_n low 2 cycles, w_doe=0, dma_ack with rdata=0xC3.
REQ-033 SHALL cover: both requesters high continuously after reset -> grants CPU, DMA, CPU, DMA, each with an IDLE gap of >=1 cycle and cs_n high between accesses.
REQ-034 SHALL cover: SETUP_CYC=3, PULSE_CYC=5, HOLD_CYC=2 -> strobe low exactly 5 cycles and ack 10 cycles after acceptance.
REQ-035 SHALL cover: rst_n low during PULSE of a write -> strobes and cs_n high, w_doe=0 on the next edge, no ack, and the next request served normally.
REQ-036 SHALL cover: w_int_n pulled low -> irq=1 two cycles later; w_int_n released -> irq=0 two cycles later.

Source files
------------

// File: rtl/w5300_pkg.sv
// Shared W5300 bus definitions: widths, FSM encoding, grant type.
// Round-robin pick helper used by the bus controller arbiter.
package w5300_pkg;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD
   } state_t;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_DMA = 1'b1
   } gnt_t;

   // On a tie the requester not granted last wins.
   function automatic gnt_t rr_pick(
      input logic cpu_req,
      input logic dma_req,
      input gnt_t last
   );
      if (cpu_req && dma_req)
         return (last == GNT_DMA) ? GNT_CPU : GNT_DMA;
      return cpu_req ? GNT_CPU : GNT_DMA;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops reset to RST_VAL so the output is quiet out of reset.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/w5300_bus_ctrl.sv
// Two-requester W5300 parallel bus controller with round-robin arbiter,
// programmable setup/pulse/hold timing and synchronized interrupt.
module w5300_bus_ctrl
   import w5300_pkg::*;
#(
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_rnw,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              dma_req,
   input  logic              dma_rnw,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              cpu_ack,
   output logic              dma_ack,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] w_addr,
   output logic              w_cs_n,
   output logic              w_rd_n,
   output logic              w_wr_n,
   output logic [DATA_W-1:0] w_dout,
   output logic              w_doe,
   input  logic [DATA_W-1:0] w_din,
   input  logic              w_int_n,
   output logic              irq
);

   localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
   localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
   localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

   state_t     st;
   logic [3:0] cnt;
   logic       rnw_q;
   gnt_t       last_gnt;
   gnt_t       win;
   logic       int_s;

   assign win = rr_pick(cpu_req, dma_req, last_gnt);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st       <= ST_IDLE;
         cnt      <= '0;
         rnw_q    <= 1'b1;
         last_gnt <= GNT_DMA;
         w_cs_n   <= 1'b1;
         w_rd_n   <= 1'b1;
         w_wr_n   <= 1'b1;
         w_doe    <= 1'b0;
         w_dout   <= '0;
         w_addr   <= '0;
         rdata    <= '0;
         cpu_ack  <= 1'b0;
         dma_ack  <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         dma_ack <= 1'b0;
         unique case (st)
            ST_IDLE: begin
               if (cpu_req || dma_req) begin
                  st       <= ST_SETUP;
                  cnt      <= SETUP_LD;
                  last_gnt <= win;
                  w_cs_n   <= 1'b0;
                  if (win == GNT_CPU) begin
                     rnw_q  <= cpu_rnw;
                     w_addr <= cpu_addr;
                     w_dout <= cpu_wdata;
                     w_doe  <= ~cpu_rnw;
                  end else begin
                     rnw_q  <= dma_rnw;
                     w_addr <= dma_addr;
                     w_dout <= dma_wdata;
                     w_doe  <= ~dma_rnw;
                  end
               end
            end
            ST_SETUP: begin
               if (cnt == 4'd0) begin
                  st     <= ST_PULSE;
                  cnt    <= PULSE_LD;
                  w_rd_n <= ~rnw_q;
                  w_wr_n <= rnw_q;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_PULSE: begin
               if (cnt == 4'd0) begin
                  st     <= ST_HOLD;
                  cnt    <= HOLD_LD;
                  w_rd_n <= 1'b1;
                  w_wr_n <= 1'b1;
                  if (rnw_q)
                     rdata <= w_din;
                  if (HOLD_LD == 4'd0) begin
                     cpu_ack <= (last_gnt == GNT_CPU);
                     dma_ack <= (last_gnt == GNT_DMA);
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_HOLD: begin
               if (cnt == 4'd0) begin
                  st     <= ST_IDLE;
                  w_cs_n <= 1'b1;
                  w_doe  <= 1'b0;
               end else begin
                  cnt <= cnt - 4'd1;
                  // ack lands in the cycle where cnt reaches zero
                  if (cnt == 4'd1) begin
                     cpu_ack <= (last_gnt == GNT_CPU);
                     dma_ack <= (last_gnt == GNT_DMA);
                  end
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   sync2 #(.RST_VAL(1'b1)) u_int_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (w_int_n),
      .q     (int_s)
   );

   assign irq = ~int_s;

endmodule

// File: tb/tb_w5300_bus_ctrl.sv
// Bench for w5300_bus_ctrl: default-timing and slow-timing instances
// driven by vector table, random transactions and corner sequences.
module tb_w5300_bus_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel = 1'b0;
   logic       cpu_req = 1'b0, cpu_rnw = 1'b0;
   logic [9:0] cpu_addr = '0;
   logic [7:0] cpu_wdata = '0;
   logic       dma_req = 1'b0, dma_rnw = 1'b0;
   logic [9:0] dma_addr = '0;
   logic [7:0] dma_wdata = '0;
   logic [7:0] w_din = '0;
   logic       w_int_n = 1'b1;

   logic       cpu_req1, dma_req1, cpu_req2, dma_req2;
   logic       cpu_ack1, dma_ack1, cs1, rd1, wr1, doe1, irq1;
   logic       cpu_ack2, dma_ack2, cs2, rd2, wr2, doe2, irq2;
   logic [7:0] rdata1, dout1, rdata2, dout2;
   logic [9:0] addr1, addr2;

   logic       o_cpu_ack, o_dma_ack, o_cs_n, o_rd_n, o_wr_n, o_doe;
   logic [7:0] o_rdata, o_dout;
   logic [9:0] o_addr;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   assign cpu_req1 = cpu_req & ~sel;
   assign dma_req1 = dma_req & ~sel;
   assign cpu_req2 = cpu_req & sel;
   assign dma_req2 = dma_req & sel;

   assign o_cpu_ack = sel ? cpu_ack2 : cpu_ack1;
   assign o_dma_ack = sel ? dma_ack2 : dma_ack1;
   assign o_cs_n    = sel ? cs2 : cs1;
   assign o_rd_n    = sel ? rd2 : rd1;
   assign o_wr_n    = sel ? wr2 : wr1;
   assign o_doe     = sel ? doe2 : doe1;
   assign o_rdata   = sel ? rdata2 : rdata1;
   assign o_dout    = sel ? dout2 : dout1;
   assign o_addr    = sel ? addr2 : addr1;

   w5300_bus_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req1), .cpu_rnw(cpu_rnw),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .dma_req(dma_req1), .dma_rnw(dma_rnw),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .cpu_ack(cpu_ack1), .dma_ack(dma_ack1), .rdata(rdata1),
      .w_addr(addr1), .w_cs_n(cs1), .w_rd_n(rd1), .w_wr_n(wr1),
      .w_dout(dout1), .w_doe(doe1), .w_din(w_din),
      .w_int_n(w_int_n), .irq(irq1)
   );

   w5300_bus_ctrl #(.SETUP_CYC(3), .PULSE_CYC(5), .HOLD_CYC(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req2), .cpu_rnw(cpu_rnw),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .dma_req(dma_req2), .dma_rnw(dma_rnw),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .cpu_ack(cpu_ack2), .dma_ack(dma_ack2), .rdata(rdata2),
      .w_addr(addr2), .w_cs_n(cs2), .w_rd_n(rd2), .w_wr_n(wr2),
      .w_dout(dout2), .w_doe(doe2), .w_din(w_din),
      .w_int_n(w_int_n), .irq(irq2)
   );

   typedef struct {
      bit         s;
      bit         who;
      bit         rnw;
      logic [9:0] a;
      logic [7:0] wd;
      logic [7:0] din;
      logic [7:0] exp_rd;
      int         exp_lat;
      int         exp_pulse;
   } vec_t;

   vec_t tbl[6];
   logic [7:0] rd_model[2];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_txn(input bit s, input bit who, input bit rnw,
                         input logic [9:0] a, input logic [7:0] wd,
                         input logic [7:0] din, input logic [7:0] exp_rd,
                         input int exp_lat, input int exp_pulse);
      int k, cs_cnt, st_cnt;
      bit got, bad;
      k = 0; cs_cnt = 0; st_cnt = 0; got = 0; bad = 0;
      @(negedge clk);
      sel = s;
      w_din = din;
      if (!who) begin
         cpu_req = 1; cpu_rnw = rnw; cpu_addr = a; cpu_wdata = wd;
      end else begin
         dma_req = 1; dma_rnw = rnw; dma_addr = a; dma_wdata = wd;
      end
      while (!got && k < 40) begin
         @(negedge clk);
         k++;
         if (!o_cs_n) begin
            cs_cnt++;
            if (o_addr !== a) bad = 1;
            if (rnw ? (o_doe !== 1'b0)
                    : (o_doe !== 1'b1 || o_dout !== wd)) bad = 1;
         end else if (o_doe !== 1'b0) bad = 1;
         if (!o_rd_n && !o_wr_n) bad = 1;
         if (rnw ? !o_wr_n : !o_rd_n) bad = 1;
         if (rnw ? !o_rd_n : !o_wr_n) st_cnt++;
         if (who ? o_cpu_ack : o_dma_ack) bad = 1;
         if (who ? o_dma_ack : o_cpu_ack) got = 1;
      end
      chk("ack_seen", 32'(got), 32'd1);
      chk("ack_latency", k, exp_lat);
      chk("cs_low_cycles", cs_cnt, exp_lat);
      chk("strobe_low_cycles", st_cnt, exp_pulse);
      chk("rdata", 32'(o_rdata), 32'(exp_rd));
      chk("bus_rules", 32'(bad), 32'd0);
      cpu_req = 0;
      dma_req = 0;
      @(negedge clk);
      chk("idle_gap",
          {26'd0, o_cs_n, o_rd_n, o_wr_n, o_doe, o_cpu_ack, o_dma_ack},
          32'b111000);
   endtask

   initial begin
      int n, k;
      bit gap_bad, prev_ack, ack_flag;
      bit order[4];
      bit last_gnt, exp_w;
      bit s, who, rnw;
      logic [9:0] a;
      logic [7:0] wd, din, exp_rd;

      tbl[0] = '{0, 0, 0, 10'h3A5, 8'h5C, 8'h00, 8'h00, 4, 2};
      tbl[1] = '{0, 1, 1, 10'h012, 8'h00, 8'hC3, 8'hC3, 4, 2};
      tbl[2] = '{0, 0, 1, 10'h1FF, 8'hEE, 8'h7E, 8'h7E, 4, 2};
      tbl[3] = '{0, 1, 0, 10'h000, 8'hAA, 8'h11, 8'h7E, 4, 2};
      tbl[4] = '{1, 0, 0, 10'h155, 8'h3C, 8'h22, 8'h00, 10, 5};
      tbl[5] = '{1, 1, 1, 10'h2AA, 8'h00, 8'h96, 8'h96, 10, 5};

      do_reset();
      @(negedge clk);
      chk("rst_bus1", {25'd0, cs1, rd1, wr1, doe1, cpu_ack1, dma_ack1, irq1},
          32'b1110000);
      chk("rst_bus2", {25'd0, cs2, rd2, wr2, doe2, cpu_ack2, dma_ack2, irq2},
          32'b1110000);
      chk("rst_data1", {rdata1, dout1, 6'd0, addr1}, 32'd0);
      chk("rst_data2", {rdata2, dout2, 6'd0, addr2}, 32'd0);

      w_int_n = 1'b0;
      @(negedge clk);
      chk("irq_assert_1cyc", {30'd0, irq1, irq2}, 32'b00);
      @(negedge clk);
      chk("irq_assert_2cyc", {30'd0, irq1, irq2}, 32'b11);
      w_int_n = 1'b1;
      @(negedge clk);
      chk("irq_release_1cyc", {30'd0, irq1, irq2}, 32'b11);
      @(negedge clk);
      chk("irq_release_2cyc", {30'd0, irq1, irq2}, 32'b00);

      rd_model[0] = 8'h00;
      rd_model[1] = 8'h00;
      for (int i = 0; i < 6; i++) begin
         do_txn(tbl[i].s, tbl[i].who, tbl[i].rnw, tbl[i].a, tbl[i].wd,
                tbl[i].din, tbl[i].exp_rd, tbl[i].exp_lat, tbl[i].exp_pulse);
         if (tbl[i].rnw) rd_model[tbl[i].s] = tbl[i].din;
      end

      for (int i = 0; i < 24; i++) begin
         s   = 1'($urandom_range(0, 1));
         who = 1'($urandom_range(0, 1));
         rnw = 1'($urandom_range(0, 1));
         a   = 10'($urandom_range(0, 1023));
         wd  = 8'($urandom_range(0, 255));
         din = 8'($urandom_range(0, 255));
         if (rnw) rd_model[s] = din;
         exp_rd = rd_model[s];
         do_txn(s, who, rnw, a, wd, din, exp_rd,
                s ? 3 + 5 + 2 : 1 + 2 + 1, s ? 5 : 2);
      end

      sel = 1'b0;
      do_reset();
      @(negedge clk);
      cpu_req = 1; cpu_rnw = 0; cpu_addr = 10'h101; cpu_wdata = 8'h5A;
      dma_req = 1; dma_rnw = 1; dma_addr = 10'h202; w_din = 8'h33;
      n = 0; k = 0; gap_bad = 0; prev_ack = 0;
      while (n < 4 && k < 200) begin
         @(negedge clk);
         k++;
         if (prev_ack && !o_cs_n) gap_bad = 1;
         prev_ack = o_cpu_ack | o_dma_ack;
         if (o_cpu_ack && o_dma_ack) gap_bad = 1;
         if (o_cpu_ack) begin order[n] = 0; n++; end
         else if (o_dma_ack) begin order[n] = 1; n++; end
      end
      cpu_req = 0;
      dma_req = 0;
      @(negedge clk);
      if (!o_cs_n) gap_bad = 1;
      chk("arb_grant_count", n, 4);
      last_gnt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_w = ~last_gnt;
         last_gnt = exp_w;
         chk($sformatf("arb_grant_%0d", i), 32'(order[i]), 32'(exp_w));
      end
      chk("arb_idle_gaps", 32'(gap_bad), 32'd0);

      @(negedge clk);
      cpu_req = 1; cpu_rnw = 0; cpu_addr = 10'h0F0; cpu_wdata = 8'h11;
      k = 0;
      while (o_wr_n && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("reached_pulse", 32'(o_wr_n), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_abort_bus", {28'd0, o_cs_n, o_rd_n, o_wr_n, o_doe},
          32'b1110);
      chk("rst_abort_ack", {30'd0, o_cpu_ack, o_dma_ack}, 32'd0);
      rst_n = 1'b1;
      cpu_req = 0;
      ack_flag = 0;
      repeat (6) begin
         @(negedge clk);
         if (o_cpu_ack || o_dma_ack || !o_cs_n) ack_flag = 1;
      end
      chk("rst_no_late_ack", 32'(ack_flag), 32'd0);
      do_txn(0, 0, 1, 10'h0F0, 8'h00, 8'hA5, 8'hA5, 4, 2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
